// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply / multiply-accumulate unit with architectural HI/LO registers.
// Optional macro MUL_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module hilo_muldiv_unit #(
  parameter int BITS_PER_CYCLE = 2,
  parameter int WIDTH          = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cancel,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  // Op[2:1] selects how the product is combined with the saved {HI,LO}.
  localparam logic [1:0] KIND_MULT = 2'b00;
  localparam logic [1:0] KIND_MADD = 2'b01;
  localparam logic [1:0] KIND_MSUB = 2'b10;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   saved;
  logic                 neg;
  logic [1:0]           kind;
  logic [CNT_W-1:0]     cnt;

  logic                 is_signed;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   prod_next;
  logic [WIDTH-1:0]     mplier_next;
  logic                 calc_last;
  logic [2*WIDTH-1:0]   signed_prod;
  logic [2*WIDTH-1:0]   commit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_signed   = ~Op[0];
    a_mag       = (is_signed && A[WIDTH-1]) ? -A : A;
    b_mag       = (is_signed && B[WIDTH-1]) ? -B : B;
    prod_next   = prod + mcand * (2*WIDTH)'(mplier[BITS_PER_CYCLE-1:0]);
    mplier_next = mplier >> BITS_PER_CYCLE;
`ifdef MUL_EARLY_TERM_EN
    calc_last   = (mplier_next == '0) || (cnt == CNT_W'(N - 1));
`else
    calc_last   = (cnt == CNT_W'(N - 1));
`endif
    signed_prod = neg ? -prod : prod;
    commit      = signed_prod;
    case (kind)
      KIND_MULT: commit = signed_prod;
      KIND_MADD: commit = saved + signed_prod;
      KIND_MSUB: commit = saved - signed_prod;
      default:   commit = signed_prod;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      saved  <= '0;
      neg    <= 1'b0;
      kind   <= KIND_MULT;
      cnt    <= '0;
      Done   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && !Cancel) begin
            if (Op == 3'b110) begin
              HI <= A;
            end else if (Op == 3'b111) begin
              LO <= A;
            end else begin
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplier <= b_mag;
              prod   <= '0;
              saved  <= {HI, LO};
              neg    <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
              kind   <= Op[2:1];
              cnt    <= '0;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (Cancel) begin
            state <= IDLE;
          end else begin
            prod   <= prod_next;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier_next;
            cnt    <= cnt + CNT_W'(1);
            if (calc_last) begin
              state <= FINISH;
              Done  <= 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          if (!Cancel) {HI, LO} <= commit;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state != IDLE);

endmodule
